// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: river ride state encoding and screen/frog geometry.
package frogger_pkg;

  localparam logic [10:0] SCREEN_X_MAX = 11'd639;
  localparam logic [10:0] FROG_SIZE    = 11'd32;
  localparam int unsigned TIMER_W      = 8;
  localparam int unsigned FRAMES_W     = 8;

  typedef enum logic [2:0] {
    OFF_ROW = 3'd0,
    GRACE   = 3'd1,
    RIDING  = 3'd2,
    SINKING = 3'd3,
    DROWNED = 3'd4
  } ride_state_t;

  // Saturating increment for the ride frame counter.
  function automatic logic [FRAMES_W-1:0] sat_inc(input logic [FRAMES_W-1:0] v);
    return (v == '1) ? v : v + FRAMES_W'(1);
  endfunction

endpackage

// File: rtl/ride_frame_timer.sv
// Frame countdown: load a start value, decrement toward zero, flag when empty.
module ride_frame_timer
  import frogger_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/river_ride_ctrl.sv
// River row ride controller: carries the frog on a lily pad, times grace/sink, raises drown.
// Optional build macro RIVER_SINK_GRACE_EN enables the SINKING state and its countdown.
module river_ride_ctrl #(
  parameter logic [10:0] ROW_HEIGHT   = 11'd40,
  parameter logic [10:0] SCREEN_X_MAX = frogger_pkg::SCREEN_X_MAX,
  parameter logic [10:0] FROG_SIZE    = frogger_pkg::FROG_SIZE,
  parameter int unsigned GRACE_FRAMES = 2,
  parameter int unsigned SINK_FRAMES  = 8
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [10:0] Row_Y,
  input  logic [10:0] Frog_X,
  input  logic [10:0] Frog_Y,
  input  logic        LPad_Collision,
  input  logic [5:0]  LPad_Remainder_Count,
  input  logic        Direction,
  input  logic        Respawn_Ack,
  output logic        Ride_Step,
  output logic        Ride_Dir,
  output logic        Drown_Req,
  output logic [2:0]  Ride_State,
  output logic [7:0]  Ride_Frames
);

  import frogger_pkg::*;

  ride_state_t state;
  logic        in_row_c;
  logic        edge_hit_c;
  logic        step_c;
  logic        grace_load_c;
  logic        grace_dec_c;
  logic        grace_zero_c;
  logic [11:0] row_end_c;

  // 12-bit geometry so Row_Y + ROW_HEIGHT cannot wrap.
  always_comb begin
    row_end_c  = {1'b0, Row_Y} + {1'b0, ROW_HEIGHT};
    in_row_c   = ({1'b0, Frog_Y} >= {1'b0, Row_Y}) && ({1'b0, Frog_Y} < row_end_c);
    edge_hit_c = Direction ? ((12'(Frog_X) + 12'(FROG_SIZE)) > 12'(SCREEN_X_MAX))
                           : (Frog_X == 11'd0);
    step_c     = (state == RIDING) && LPad_Collision &&
                 (LPad_Remainder_Count == 6'd0) && !edge_hit_c;
  end

  always_comb begin
    grace_load_c = (state == OFF_ROW) && in_row_c;
    grace_dec_c  = (state == GRACE) && in_row_c && !grace_zero_c;
  end

  ride_frame_timer #(.W(TIMER_W)) u_grace_timer (
    .clk      (frame_clk),
    .rst      (Reset),
    .load     (grace_load_c),
    .load_val (TIMER_W'(GRACE_FRAMES - 1)),
    .dec      (grace_dec_c),
    .zero_c   (grace_zero_c)
  );

`ifdef RIVER_SINK_GRACE_EN
  logic sink_load_c;
  logic sink_dec_c;
  logic sink_zero_c;

  always_comb begin
    sink_load_c = in_row_c && !LPad_Collision &&
                  ((state == RIDING) || ((state == GRACE) && grace_zero_c));
    sink_dec_c  = (state == SINKING) && in_row_c && !LPad_Collision && !sink_zero_c;
  end

  ride_frame_timer #(.W(TIMER_W)) u_sink_timer (
    .clk      (frame_clk),
    .rst      (Reset),
    .load     (sink_load_c),
    .load_val (TIMER_W'(SINK_FRAMES - 1)),
    .dec      (sink_dec_c),
    .zero_c   (sink_zero_c)
  );

  localparam ride_state_t LOST_STATE = SINKING;
`else
  localparam ride_state_t LOST_STATE = DROWNED;
`endif

  // Ride FSM with registered step/dir/drown/frame-count outputs.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= OFF_ROW;
      Ride_Step   <= 1'b0;
      Ride_Dir    <= 1'b0;
      Drown_Req   <= 1'b0;
      Ride_Frames <= '0;
    end else begin
      Ride_Dir  <= Direction;
      Ride_Step <= step_c;
      if (step_c) begin
        Ride_Frames <= sat_inc(Ride_Frames);
      end
      case (state)
        OFF_ROW: begin
          if (in_row_c) begin
            state       <= GRACE;
            Ride_Frames <= '0;
          end
        end
        GRACE: begin
          if (!in_row_c) begin
            state <= OFF_ROW;
          end else if (grace_zero_c) begin
            state     <= LPad_Collision ? RIDING : LOST_STATE;
            Drown_Req <= !LPad_Collision && (LOST_STATE == DROWNED);
          end
        end
        RIDING: begin
          if (!in_row_c) begin
            state <= OFF_ROW;
          end else if (!LPad_Collision) begin
            state     <= LOST_STATE;
            Drown_Req <= (LOST_STATE == DROWNED);
          end else if (edge_hit_c) begin
            state     <= DROWNED;
            Drown_Req <= 1'b1;
          end
        end
`ifdef RIVER_SINK_GRACE_EN
        SINKING: begin
          if (!in_row_c) begin
            state <= OFF_ROW;
          end else if (LPad_Collision) begin
            state <= RIDING;
          end else if (sink_zero_c) begin
            state     <= DROWNED;
            Drown_Req <= 1'b1;
          end
        end
`endif
        DROWNED: begin
          if (Respawn_Ack) begin
            state     <= OFF_ROW;
            Drown_Req <= 1'b0;
          end
        end
        default: begin
          state     <= OFF_ROW;
          Drown_Req <= 1'b0;
        end
      endcase
    end
  end

  assign Ride_State = 3'(state);

endmodule

// File: tb/tb_river_ride_ctrl.sv
// Directed bench for river_ride_ctrl: vector table plus hand sequences for sink/drown/reset/saturation.
module tb_river_ride_ctrl;

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_GRACE = 3'd1;
  localparam logic [2:0] S_RIDE  = 3'd2;
  localparam logic [2:0] S_SINK  = 3'd3;
  localparam logic [2:0] S_DROWN = 3'd4;
  localparam int NVEC = 19;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [10:0] Row_Y, Frog_X, Frog_Y;
  logic        LPad_Collision;
  logic [5:0]  LPad_Remainder_Count;
  logic        Direction, Respawn_Ack;
  logic        Ride_Step, Ride_Dir, Drown_Req;
  logic [2:0]  Ride_State;
  logic [7:0]  Ride_Frames;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [10:0] fx;
    logic [10:0] fy;
    logic        coll;
    logic [5:0]  rem;
    logic        dir;
    logic        ack;
    logic [2:0]  st;
    logic        step;
    logic        rdir;
    logic        drown;
    logic [7:0]  frames;
  } vec_t;

  vec_t vecs [NVEC];

  river_ride_ctrl dut (
    .frame_clk            (frame_clk),
    .Reset                (Reset),
    .Row_Y                (Row_Y),
    .Frog_X               (Frog_X),
    .Frog_Y               (Frog_Y),
    .LPad_Collision       (LPad_Collision),
    .LPad_Remainder_Count (LPad_Remainder_Count),
    .Direction            (Direction),
    .Respawn_Ack          (Respawn_Ack),
    .Ride_Step            (Ride_Step),
    .Ride_Dir             (Ride_Dir),
    .Drown_Req            (Drown_Req),
    .Ride_State           (Ride_State),
    .Ride_Frames          (Ride_Frames)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic vec_t mk(input logic [10:0] fx, input logic [10:0] fy, input logic coll,
                              input logic [5:0] rem, input logic dir, input logic ack,
                              input logic [2:0] st, input logic step, input logic rdir,
                              input logic drown, input logic [7:0] frames);
    vec_t v;
    v = '{fx, fy, coll, rem, dir, ack, st, step, rdir, drown, frames};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [10:0] fx, input logic [10:0] fy, input logic coll,
                       input logic [5:0] rem, input logic dir, input logic ack);
    Frog_X = fx; Frog_Y = fy; LPad_Collision = coll;
    LPad_Remainder_Count = rem; Direction = dir; Respawn_Ack = ack;
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Pulse reset, enter the row on a pad, and ride two steps (Ride_Frames=2).
  task automatic to_riding();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    drive(11'd300, 11'd100, 1'b1, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("to_riding_state", 32'(Ride_State), 32'(S_RIDE));
    chk("to_riding_frames", 32'(Ride_Frames), 32'd2);
  endtask

  initial begin
    Reset = 1'b1;
    Row_Y = 11'd100;
    drive(11'd300, 11'd50, 1'b0, 6'd0, 1'b1, 1'b0);

    //        fx      fy    coll rem   dir ack | st      step rdir drown frames
    vecs[0]  = mk(11'd300, 11'd50,  0, 6'd0, 1, 0, S_OFF,   0, 1, 0, 8'd0);
    vecs[1]  = mk(11'd300, 11'd100, 1, 6'd0, 1, 0, S_GRACE, 0, 1, 0, 8'd0);
    vecs[2]  = mk(11'd300, 11'd100, 1, 6'd0, 1, 0, S_GRACE, 0, 1, 0, 8'd0);
    vecs[3]  = mk(11'd300, 11'd100, 1, 6'd0, 1, 0, S_RIDE,  0, 1, 0, 8'd0);
    vecs[4]  = mk(11'd300, 11'd100, 1, 6'd0, 1, 0, S_RIDE,  1, 1, 0, 8'd1);
    vecs[5]  = mk(11'd300, 11'd100, 1, 6'd0, 0, 0, S_RIDE,  1, 0, 0, 8'd2);
    vecs[6]  = mk(11'd300, 11'd100, 1, 6'd5, 0, 0, S_RIDE,  0, 0, 0, 8'd2);
    vecs[7]  = mk(11'd0,   11'd100, 1, 6'd0, 0, 0, S_DROWN, 0, 0, 1, 8'd2);
    vecs[8]  = mk(11'd0,   11'd50,  0, 6'd0, 0, 0, S_DROWN, 0, 0, 1, 8'd2);
    vecs[9]  = mk(11'd0,   11'd50,  0, 6'd0, 1, 1, S_OFF,   0, 1, 0, 8'd2);
    vecs[10] = mk(11'd300, 11'd139, 0, 6'd0, 1, 0, S_GRACE, 0, 1, 0, 8'd0);
    vecs[11] = mk(11'd300, 11'd140, 0, 6'd0, 1, 0, S_OFF,   0, 1, 0, 8'd0);
    vecs[12] = mk(11'd300, 11'd50,  0, 6'd0, 1, 1, S_OFF,   0, 1, 0, 8'd0);
    vecs[13] = mk(11'd607, 11'd100, 1, 6'd0, 1, 0, S_GRACE, 0, 1, 0, 8'd0);
    vecs[14] = mk(11'd607, 11'd100, 1, 6'd0, 1, 0, S_GRACE, 0, 1, 0, 8'd0);
    vecs[15] = mk(11'd607, 11'd100, 1, 6'd0, 1, 0, S_RIDE,  0, 1, 0, 8'd0);
    vecs[16] = mk(11'd607, 11'd100, 1, 6'd0, 1, 0, S_RIDE,  1, 1, 0, 8'd1);
    vecs[17] = mk(11'd608, 11'd100, 1, 6'd0, 1, 0, S_DROWN, 0, 1, 1, 8'd1);
    vecs[18] = mk(11'd608, 11'd100, 1, 6'd0, 1, 1, S_OFF,   0, 1, 0, 8'd1);

    #12;
    chk("rst_state", 32'(Ride_State), 32'(S_OFF));
    chk("rst_step", 32'(Ride_Step), 32'd0);
    chk("rst_dir", 32'(Ride_Dir), 32'd0);
    chk("rst_drown", 32'(Drown_Req), 32'd0);
    chk("rst_frames", 32'(Ride_Frames), 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].fx, vecs[i].fy, vecs[i].coll, vecs[i].rem, vecs[i].dir, vecs[i].ack);
      tick();
      chk($sformatf("v%0d_state", i), 32'(Ride_State), 32'(vecs[i].st));
      chk($sformatf("v%0d_step", i), 32'(Ride_Step), 32'(vecs[i].step));
      chk($sformatf("v%0d_dir", i), 32'(Ride_Dir), 32'(vecs[i].rdir));
      chk($sformatf("v%0d_drown", i), 32'(Drown_Req), 32'(vecs[i].drown));
      chk($sformatf("v%0d_frames", i), 32'(Ride_Frames), 32'(vecs[i].frames));
    end

`ifdef RIVER_SINK_GRACE_EN
    // Pad lost for good: 8 frames sinking, then drowned.
    to_riding();
    LPad_Collision = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("sink%0d_state", i), 32'(Ride_State), 32'(S_SINK));
      chk($sformatf("sink%0d_drown", i), 32'(Drown_Req), 32'd0);
    end
    tick();
    chk("sink_end_state", 32'(Ride_State), 32'(S_DROWN));
    chk("sink_end_drown", 32'(Drown_Req), 32'd1);
`else
    // Pad lost with no sink window: drowned on the next edge.
    to_riding();
    LPad_Collision = 1'b0;
    tick();
    chk("lost_state", 32'(Ride_State), 32'(S_DROWN));
    chk("lost_drown", 32'(Drown_Req), 32'd1);
`endif

    // Asynchronous reset while drowned clears everything before the next edge.
    Reset = 1'b1;
    #1;
    chk("arst_state", 32'(Ride_State), 32'(S_OFF));
    chk("arst_step", 32'(Ride_Step), 32'd0);
    chk("arst_dir", 32'(Ride_Dir), 32'd0);
    chk("arst_drown", 32'(Drown_Req), 32'd0);
    chk("arst_frames", 32'(Ride_Frames), 32'd0);
    Reset = 1'b0;

`ifdef RIVER_SINK_GRACE_EN
    // Pad regained on the fifth frame returns to riding.
    to_riding();
    LPad_Collision = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("recov_sinking", 32'(Ride_State), 32'(S_SINK));
    LPad_Collision = 1'b1;
    tick();
    chk("recov_state", 32'(Ride_State), 32'(S_RIDE));
    chk("recov_drown", 32'(Drown_Req), 32'd0);

    // Leaving the row mid-sink abandons the drown.
    LPad_Collision = 1'b0;
    tick();
    chk("leave_sinking", 32'(Ride_State), 32'(S_SINK));
    Frog_Y = 11'd140;
    tick();
    chk("leave_state", 32'(Ride_State), 32'(S_OFF));
    chk("leave_drown", 32'(Drown_Req), 32'd0);
`endif

    // Grace expires with no pad underneath.
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    drive(11'd300, 11'd100, 1'b0, 6'd0, 1'b1, 1'b0);
    tick();
    tick();
    chk("nopad_grace", 32'(Ride_State), 32'(S_GRACE));
    tick();
`ifdef RIVER_SINK_GRACE_EN
    chk("nopad_state", 32'(Ride_State), 32'(S_SINK));
    chk("nopad_drown", 32'(Drown_Req), 32'd0);
`else
    chk("nopad_state", 32'(Ride_State), 32'(S_DROWN));
    chk("nopad_drown", 32'(Drown_Req), 32'd1);
`endif

    // Long ride saturates the step counter.
    to_riding();
    for (int i = 0; i < 300; i++) tick();
    chk("sat_frames", 32'(Ride_Frames), 32'd255);
    chk("sat_step", 32'(Ride_Step), 32'd1);
    chk("sat_state", 32'(Ride_State), 32'(S_RIDE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/river_ride_ctrl.md
RIVER_RIDE_CTRL -- requirements
Module: river_ride_ctrl

Interface
REQ-001 The module SHALL have parameter ROW_HEIGHT, default 11'd40: vertical extent of the river row in pixels.
REQ-002 The module SHALL have parameter SCREEN_X_MAX, default 11'd639: rightmost legal frog X.
REQ-003 The module SHALL have parameter FROG_SIZE, default 11'd32: frog width in pixels.
REQ-004 The module SHALL have parameter GRACE_FRAMES, default 2: frames after row entry during which LPad_Collision is ignored.
REQ-005 The module SHALL have parameter SINK_FRAMES, default 8: frames off-pad before drowning.
REQ-006 The module SHALL have these ports, clock and reset first:
 frame_clk  in  1  sole clock, one edge per video frame
 Reset  in  1  asynchronous, active-high
 Row_Y  in  11  top Y of this river row
 Frog_X, Frog_Y  in  11 each  current frog position
 LPad_Collision  in  1  frog overlaps an enabled pad in this row
 LPad_Remainder_Count  in  6  pad move phase; 0 = pads step this frame
 Direction  in  1  pad direction, 1 = right, 0 = left
 Respawn_Ack  in  1  game logic has respawned the frog
 Ride_Step  out  1  move frog 1 pixel this frame
 Ride_Dir  out  1  direction of Ride_Step
 Drown_Req  out  1  frog lost; held until acknowledged
 Ride_State  out  3  current state, encoded per the shared package
 Ride_Frames  out  8  saturating count of Ride_Step pulses since row entry

Function
REQ-007 In_Row SHALL be (Frog_Y >= Row_Y) && (Frog_Y < Row_Y + ROW_HEIGHT), computed in 12-bit arithmetic so it cannot overflow.
REQ-008 Edge_Hit SHALL be (Direction==0 && Frog_X==0) || (Direction==1 && Frog_X + FROG_SIZE > SCREEN_X_MAX).
REQ-009 The state machine SHALL have states OFF_ROW, GRACE, RIDING, SINKING and DROWNED; every output and state SHALL be registered on the frame_clk rising edge.
REQ-010 OFF_ROW: In_Row SHALL go to GRACE, load the grace counter with GRACE_FRAMES-1 and clear Ride_Frames.
REQ-011 GRACE: the state SHALL decrement each frame; when the counter is 0, LPad_Collision SHALL go to RIDING and its absence SHALL go to SINKING.
REQ-012 RIDING: no collision SHALL go to SINKING and load the sink counter with SINK_FRAMES-1; Edge_Hit with collision SHALL go to DROWNED.
REQ-013 SINKING: collision SHALL return to RIDING; when the counter reaches 0 without collision, the state SHALL go to DROWNED.
REQ-014 In GRACE, RIDING and SINKING, !In_Row SHALL go to OFF_ROW, taking priority over every other transition.
REQ-015 DROWNED SHALL ignore In_Row and collision, and SHALL go to OFF_ROW only on Respawn_Ack.
REQ-016 Drown_Req SHALL be 1 exactly while in DROWNED, and SHALL deassert on the edge where Respawn_Ack is sampled high.
REQ-017 Respawn_Ack outside DROWNED SHALL be ignored.
REQ-018 Ride_Step SHALL be 1 for the frame following an edge where the state is RIDING, LPad_Collision=1, LPad_Remainder_Count==0 and Edge_Hit=0; otherwise Ride_Step SHALL be 0.
REQ-019 Ride_Dir SHALL register Direction on every edge.
REQ-020 Ride_Frames SHALL increment with each Ride_Step and saturate at 255.

Reset
REQ-021 Reset SHALL asynchronously force: state OFF_ROW, both counters 0, Ride_Step 0, Ride_Dir 0, Drown_Req 0, Ride_Frames 0, Ride_State encoding OFF_ROW.
REQ-022 Reset asserted in any state, including DROWNED, SHALL abandon any pending drown without requiring Respawn_Ack.

Configuration
REQ-023 With RIVER_SINK_GRACE_EN defined, the SINKING state and sink counter SHALL exist as described above.
REQ-024 Without RIVER_SINK_GRACE_EN, every transition into SINKING SHALL instead go directly to DROWNED, SINKING SHALL be unreachable, and its encoding SHALL be retained.

Structure
REQ-025 Shared package frogger_pkg SHALL hold the ride_state_t enum (OFF_ROW=0, GRACE=1, RIDING=2, SINKING=3, DROWNED=4) and the SCREEN_X_MAX and FROG_SIZE constants.
REQ-026 The sink and grace countdown SHALL be one sub-module, ride_frame_timer (load, decrement, zero flag), instantiated twice.

Verification
REQ-027 Frog_Y=Row_Y, collision=1, remainder=0 every frame -> GRACE for 2 frames, then RIDING, then Ride_Step=1 each frame with Ride_Dir=Direction.
REQ-028 RIDING, then collision dropped for 8 frames -> SINKING for 8 frames, then Drown_Req=1; collision restored at frame 5 instead -> back to RIDING, no Drown_Req.
REQ-029 RIDING with Direction=0 and Frog_X=0 -> DROWNED next edge; Respawn_Ack pulse -> Drown_Req=0 and OFF_ROW.
REQ-030 Frog_Y moved to Row_Y+40 mid-SINKING -> OFF_ROW, no Drown_Req; Reset asserted in DROWNED -> all outputs 0 immediately, before the next clock edge.
REQ-031 300 Ride_Step frames -> Ride_Frames=255; build without RIVER_SINK_GRACE_EN plus collision loss -> DROWNED on the next edge.
